// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and the IF/ID register layout for the MIPS pipeline
package mips_pkg;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam int DEF_IM_WORDS = 4096;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic valid;
    logic adel;
  } ifid_t;
endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: hazard/decode controls, instruction-memory bus and IF/ID outputs of the fetch stage
interface if_stage_if;
  logic stall;
  logic redirect;
  logic [31:0] redirect_pc;
  logic [31:0] i_inst_addr;
  logic [31:0] i_inst_rdata;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic [31:0] d_pc8;
  logic d_valid;
  logic d_adel;
  logic [31:0] fetch_count;
  modport master (
    input stall, redirect, redirect_pc, i_inst_rdata,
    output i_inst_addr, d_instr, d_pc, d_pc8, d_valid, d_adel, fetch_count
  );
  modport slave (
    output stall, redirect, redirect_pc, i_inst_rdata,
    input i_inst_addr, d_instr, d_pc, d_pc8, d_valid, d_adel, fetch_count
  );
endinterface

// File: rtl/if_stage_pc_reg.sv
// pc_reg: program counter with stall/redirect next-PC mux and fetch-address error check
module pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int IM_WORDS = DEF_IM_WORDS
) (
  input logic clk,
  input logic reset,
  input logic stall,
  input logic redirect,
  input logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic adel
);
  // 33-bit bound so a memory ending at the top of the address space cannot overflow
  localparam logic [32:0] LAST = {1'b0, RESET_PC} + 33'(IM_WORDS) * 33'd4 - 33'd4;
  always_ff @(posedge clk)
    pc <= reset ? RESET_PC : stall ? pc : redirect ? redirect_pc : pc + 32'd4;
  assign adel = (pc[1:0] != 2'b00) || (pc < RESET_PC) || ({1'b0, pc} > LAST);
endmodule

// File: rtl/if_stage.sv
// if_stage: MIPS instruction fetch with PC, IF/ID register and retired-fetch counter
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int IM_WORDS = DEF_IM_WORDS
) (
  input logic clk,
  input logic reset,
  if_stage_if.master bus
);
  logic [31:0] pc;
  logic adel;
  ifid_t ifid;
  logic [31:0] count;
  pc_reg #(.RESET_PC(RESET_PC), .IM_WORDS(IM_WORDS)) u_pc (
    .clk(clk),
    .reset(reset),
    .stall(bus.stall),
    .redirect(bus.redirect),
    .redirect_pc(bus.redirect_pc),
    .pc(pc),
    .adel(adel)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      ifid <= '0;
      count <= '0;
    end else if (!bus.stall) begin
      ifid <= '{instr: adel ? NOP_INSTR : bus.i_inst_rdata, pc: pc, pc8: pc + 32'd8, valid: 1'b1, adel: adel};
      count <= adel ? count : count + 32'd1;
    end
  end
  assign bus.i_inst_addr = pc;
  assign bus.d_instr = ifid.instr;
  assign bus.d_pc = ifid.pc;
  assign bus.d_pc8 = ifid.pc8;
  assign bus.d_valid = ifid.valid;
  assign bus.d_adel = ifid.adel;
  assign bus.fetch_count = count;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: table-driven directed check of the fetch stage against hand-computed PC/IF/ID values
module tb_if_stage;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  if_stage_if bus();
  if_stage dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction
  assign bus.i_inst_rdata = mem(bus.i_inst_addr);
  typedef struct {
    logic rst;
    logic stall;
    logic redir;
    logic [31:0] rpc;
    logic [31:0] addr;
    logic [31:0] dpc;
    logic valid;
    logic adel;
    logic [31:0] cnt;
  } vec_t;
  vec_t v[$];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step(input vec_t t);
    @(negedge clk);
    reset = t.rst;
    bus.stall = t.stall;
    bus.redirect = t.redir;
    bus.redirect_pc = t.rpc;
    @(posedge clk);
    #1;
    check("i_inst_addr", bus.i_inst_addr, t.addr);
    check("d_pc", bus.d_pc, t.dpc);
    check("d_pc8", bus.d_pc8, t.valid ? t.dpc + 32'd8 : 32'h0);
    check("d_instr", bus.d_instr, (!t.valid || t.adel) ? 32'h0 : mem(t.dpc));
    check("d_valid", 32'(bus.d_valid), 32'(t.valid));
    check("d_adel", 32'(bus.d_adel), 32'(t.adel));
    check("fetch_count", bus.fetch_count, t.cnt);
  endtask
  initial begin
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    //          rst   stall redir rpc           addr          dpc           v     adel  cnt
    v.push_back('{1'b1, 1'b0, 1'b0, 32'h0,        32'h3000,     32'h0,        1'b0, 1'b0, 0});
    v.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        32'h3004,     32'h3000,     1'b1, 1'b0, 1});
    v.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        32'h3008,     32'h3004,     1'b1, 1'b0, 2});
    v.push_back('{1'b0, 1'b0, 1'b1, 32'h3100,     32'h3100,     32'h3008,     1'b1, 1'b0, 3});
    v.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        32'h3104,     32'h3100,     1'b1, 1'b0, 4});
    v.push_back('{1'b0, 1'b1, 1'b1, 32'h3200,     32'h3104,     32'h3100,     1'b1, 1'b0, 4});
    v.push_back('{1'b0, 1'b1, 1'b1, 32'h3200,     32'h3104,     32'h3100,     1'b1, 1'b0, 4});
    v.push_back('{1'b0, 1'b1, 1'b1, 32'h3200,     32'h3104,     32'h3100,     1'b1, 1'b0, 4});
    v.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        32'h3108,     32'h3104,     1'b1, 1'b0, 5});
    v.push_back('{1'b0, 1'b0, 1'b1, 32'h3102,     32'h3102,     32'h3108,     1'b1, 1'b0, 6});
    v.push_back('{1'b0, 1'b0, 1'b1, 32'h7000,     32'h7000,     32'h3102,     1'b1, 1'b1, 6});
    v.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        32'h7004,     32'h7000,     1'b1, 1'b1, 6});
    v.push_back('{1'b0, 1'b0, 1'b1, 32'h3000,     32'h3000,     32'h7004,     1'b1, 1'b1, 6});
    v.push_back('{1'b1, 1'b1, 1'b1, 32'h5000,     32'h3000,     32'h0,        1'b0, 1'b0, 0});
    v.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        32'h3004,     32'h3000,     1'b1, 1'b0, 1});
    v.push_back('{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h3004,     1'b1, 1'b0, 2});
    v.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'hFFFF_FFFC, 1'b1, 1'b1, 2});
    v.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        32'h0,        1'b1, 1'b1, 2});
    v.push_back('{1'b0, 1'b0, 1'b1, 32'h6FFC,     32'h6FFC,     32'h4,        1'b1, 1'b1, 2});
    v.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        32'h7000,     32'h6FFC,     1'b1, 1'b0, 3});
    v.push_back('{1'b0, 1'b0, 1'b1, 32'h2FFC,     32'h2FFC,     32'h7000,     1'b1, 1'b1, 3});
    v.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        32'h3000,     32'h2FFC,     1'b1, 1'b1, 3});
    v.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        32'h3004,     32'h3000,     1'b1, 1'b0, 4});
    foreach (v[i]) step(v[i]);
    // stalled branch re-presents its redirect once the stall clears
    step('{1'b0, 1'b1, 1'b1, 32'h3400, 32'h3004, 32'h3000, 1'b1, 1'b0, 4});
    step('{1'b0, 1'b1, 1'b1, 32'h3400, 32'h3004, 32'h3000, 1'b1, 1'b0, 4});
    step('{1'b0, 1'b0, 1'b1, 32'h3400, 32'h3400, 32'h3004, 1'b1, 1'b0, 5});
    step('{1'b0, 1'b0, 1'b0, 32'h0,    32'h3404, 32'h3400, 1'b1, 1'b0, 6});
    // reset while redirecting and stalling
    step('{1'b1, 1'b1, 1'b1, 32'h3800, 32'h3000, 32'h0,    1'b0, 1'b0, 0});
    step('{1'b0, 1'b1, 1'b0, 32'h0,    32'h3000, 32'h0,    1'b0, 1'b0, 0});
    step('{1'b0, 1'b0, 1'b0, 32'h0,    32'h3004, 32'h3000, 1'b1, 1'b0, 1});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
